// File: rtl/uart_hex_rx.sv
// UART 8N1 receiver feeding a hex-line parser that assembles 64-bit qwords.
// A line is eight "hh " groups then LF; results leave through valid/ready.

module uart_hex_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [63:0] qword_out,
   output logic        qword_valid,
   input  logic        qword_ready,
   output logic        err_fmt,
   output logic        err_frame,
   output logic        err_ovf
);

   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_SP = 8'h20;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_st_e;

   typedef enum logic [2:0] {
      P_HI,
      P_LO,
      P_SEP,
      P_EOL,
      P_DISCARD
   } p_st_e;

   // synchroniser and edge history
   logic        meta_q;
   logic        sync_q;
   logic        prev_q;

   // receiver
   rx_st_e      rx_st_q, rx_st_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  sh_q, sh_d;
   logic        bvld_q, bvld_d;
   logic        frm_q, frm_d;

   // parser
   p_st_e       pst_q, pst_d;
   logic [3:0]  bcnt_q, bcnt_d;
   logic [63:0] asm_q, asm_d;
   logic        fmt_q, fmt_d;
   logic        dlv_q, dlv_d;
   logic        is_hex;
   logic [3:0]  nib;
   logic        is_lf;
   logic        is_cr;
   logic        is_sp;
   logic        bad;

   // output port
   logic [63:0] qo_q, qo_d;
   logic        qv_q, qv_d;
   logic        ovf_q, ovf_d;
   logic        xfer;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   always_comb begin
      rx_st_d = rx_st_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      bvld_d  = 1'b0;
      frm_d   = 1'b0;
      unique case (rx_st_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (prev_q && !sync_q) begin
               rx_st_d = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               rx_st_d = sync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               sh_d  = {sync_q, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_st_d = RX_STOP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               rx_st_d = RX_IDLE;
               if (sync_q) begin
                  bvld_d = 1'b1;
               end else begin
                  frm_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            rx_st_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_st_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         bvld_q  <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         rx_st_q <= rx_st_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         bvld_q  <= bvld_d;
         frm_q   <= frm_d;
      end
   end

   // sh_q stays put until the next data sample, so it is the strobed byte
   always_comb begin
      is_hex = 1'b0;
      nib    = 4'h0;
      if (sh_q >= 8'h30 && sh_q <= 8'h39) begin
         is_hex = 1'b1;
         nib    = sh_q[3:0];
      end else if ((sh_q >= 8'h41 && sh_q <= 8'h46) ||
                   (sh_q >= 8'h61 && sh_q <= 8'h66)) begin
         is_hex = 1'b1;
         nib    = sh_q[3:0] + 4'd9;
      end
   end

   assign is_lf = (sh_q == CH_LF);
   assign is_cr = (sh_q == CH_CR);
   assign is_sp = (sh_q == CH_SP);

   always_comb begin
      pst_d  = pst_q;
      bcnt_d = bcnt_q;
      asm_d  = asm_q;
      fmt_d  = 1'b0;
      dlv_d  = 1'b0;
      bad    = 1'b0;
      if (frm_q) begin
         pst_d = P_DISCARD;
      end else if (bvld_q) begin
         unique case (pst_q)
            P_HI: begin
               if (is_hex) begin
                  asm_d = {asm_q[59:0], nib};
                  pst_d = P_LO;
               end else begin
                  bad = 1'b1;
               end
            end
            P_LO: begin
               if (is_hex) begin
                  asm_d = {asm_q[59:0], nib};
                  pst_d = P_SEP;
               end else begin
                  bad = 1'b1;
               end
            end
            P_SEP: begin
               if (is_sp) begin
                  bcnt_d = bcnt_q + 4'd1;
                  pst_d  = (bcnt_q == 4'd7) ? P_EOL : P_HI;
               end else begin
                  bad = 1'b1;
               end
            end
            P_EOL: begin
               if (is_lf) begin
                  dlv_d  = 1'b1;
                  pst_d  = P_HI;
                  bcnt_d = '0;
               end else if (!is_cr) begin
                  bad = 1'b1;
               end
            end
            P_DISCARD: begin
               if (is_lf) begin
                  pst_d  = P_HI;
                  bcnt_d = '0;
               end
            end
            default: begin
               pst_d = P_DISCARD;
            end
         endcase
         // a stray LF already ends the line, so resync straight away
         if (bad) begin
            fmt_d = 1'b1;
            if (is_lf) begin
               pst_d  = P_HI;
               bcnt_d = '0;
            end else begin
               pst_d = P_DISCARD;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pst_q  <= P_HI;
         bcnt_q <= '0;
         asm_q  <= '0;
         fmt_q  <= 1'b0;
         dlv_q  <= 1'b0;
      end else begin
         pst_q  <= pst_d;
         bcnt_q <= bcnt_d;
         asm_q  <= asm_d;
         fmt_q  <= fmt_d;
         dlv_q  <= dlv_d;
      end
   end

   assign xfer = qv_q & qword_ready;

   always_comb begin
      qo_d  = qo_q;
      qv_d  = qv_q;
      ovf_d = 1'b0;
      if (dlv_q) begin
         if (!qv_q || xfer) begin
            qo_d = asm_q;
            qv_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (xfer) begin
         qv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qo_q  <= '0;
         qv_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         qo_q  <= qo_d;
         qv_q  <= qv_d;
         ovf_q <= ovf_d;
      end
   end

   assign qword_out   = qo_q;
   assign qword_valid = qv_q;
   assign err_fmt     = fmt_q;
   assign err_frame   = frm_q;
   assign err_ovf     = ovf_q;

endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: serial lines in, line-level model predicts
// qwords and error pulse counts, one process compares every cycle.

module tb_uart_hex_rx;

   localparam int C = 8;

   logic        clk;
   logic        rst;
   logic        rx;
   logic        qword_ready;
   logic [63:0] qword_out;
   logic        qword_valid;
   logic        err_fmt;
   logic        err_frame;
   logic        err_ovf;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] exp_q[$];
   bit          held_v = 0;
   logic [63:0] held_w = '0;
   int exp_fmt = 0;
   int exp_frm = 0;
   int exp_ovf = 0;
   int obs_fmt = 0;
   int obs_frm = 0;
   int obs_ovf = 0;

   bit          pv = 0;
   bit          pr = 0;
   logic [63:0] po = '0;
   logic [63:0] wexp;

   uart_hex_rx #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .qword_out  (qword_out),
      .qword_valid(qword_valid),
      .qword_ready(qword_ready),
      .err_fmt    (err_fmt),
      .err_frame  (err_frame),
      .err_ovf    (err_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
      if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
      if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
      return -1;
   endfunction

   // whole-line grammar: 8 x (hex hex space), any CRs, one LF
   function automatic bit parse_line(input string s,
                                     output logic [63:0] w);
      w = '0;
      if (s.len() < 25) return 0;
      for (int g = 0; g < 8; g++) begin
         for (int k = 0; k < 2; k++) begin
            int h;
            h = hexval(s[3*g+k]);
            if (h < 0) return 0;
            w = (w << 4) | 64'(h);
         end
         if (s[3*g+2] != 8'h20) return 0;
      end
      for (int i = 24; i < s.len() - 1; i++) begin
         if (s[i] != 8'h0D) return 0;
      end
      return s[s.len()-1] == 8'h0A;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rx = 1'b0;
      tick(C);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(C);
      end
      rx = stop;
      tick(C);
      rx = 1'b1;
      tick(C);
   endtask

   task automatic send_line(input string s, input int bad);
      logic [63:0] w;
      bit ok;
      if (bad >= 0) begin
         exp_frm++;
      end else begin
         ok = parse_line(s, w);
         if (!ok) exp_fmt++;
         else if (qword_ready) exp_q.push_back(w);
         else if (!held_v) begin
            held_v = 1;
            held_w = w;
         end else exp_ovf++;
      end
      for (int i = 0; i < s.len(); i++) send_byte(s[i], i != bad);
   endtask

   task automatic checkpoint(input string tag, input logic [63:0] last);
      tick(4);
      check({tag, ":pending"}, 64'(exp_q.size()), 64'd0);
      check({tag, ":fmt"}, 64'(obs_fmt), 64'(exp_fmt));
      check({tag, ":frame"}, 64'(obs_frm), 64'(exp_frm));
      check({tag, ":ovf"}, 64'(obs_ovf), 64'(exp_ovf));
      check({tag, ":valid"}, 64'(qword_valid), 64'(held_v));
      check({tag, ":out"}, qword_out, last);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ":out"}, qword_out, 64'd0);
      check({tag, ":valid"}, 64'(qword_valid), 64'd0);
      check({tag, ":efmt"}, 64'(err_fmt), 64'd0);
      check({tag, ":eframe"}, 64'(err_frame), 64'd0);
      check({tag, ":eovf"}, 64'(err_ovf), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         pv = 0;
         pr = 0;
      end else begin
         if (pv && !pr) begin
            n_chk++;
            if (!qword_valid || qword_out !== po) begin
               n_fail++;
               $display("FAIL hold: valid=%0b out=%h required valid=1 out=%h",
                        qword_valid, qword_out, po);
            end
         end
         if (qword_valid && qword_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL xfer: got qword %h required no transfer",
                        qword_out);
            end else begin
               wexp = exp_q.pop_front();
               check("xfer", qword_out, wexp);
            end
         end
         obs_fmt += int'(err_fmt);
         obs_frm += int'(err_frame);
         obs_ovf += int'(err_ovf);
         pv = qword_valid;
         pr = qword_ready;
         po = qword_out;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      string ln;
      rst = 1'b0;
      rx = 1'b1;
      qword_ready = 1'b1;
      tick(3);
      check_reset_outputs("por");
      rst = 1'b1;
      tick(3 * C);

      send_line("01 23 45 67 89 AB CD EF \n", -1);
      checkpoint("upper", 64'h0123456789ABCDEF);

      send_line("de ad be ef 00 11 22 33 \015\n", -1);
      checkpoint("lower_cr", 64'hDEADBEEF00112233);

      send_line("01 2G 45 67 89 AB CD EF \n", -1);
      checkpoint("bad_hex", 64'hDEADBEEF00112233);
      send_line("FF FF FF FF FF FF FF FF \n", -1);
      checkpoint("all_ff", 64'hFFFFFFFFFFFFFFFF);

      send_line("01 23 45 \n", -1);
      checkpoint("short", 64'hFFFFFFFFFFFFFFFF);
      send_line("5A A5 5A A5 5A A5 5A A5 \n", -1);
      checkpoint("after_short", 64'h5AA55AA55AA55AA5);

      qword_ready = 1'b0;
      send_line("AA BB CC DD EE FF 00 11 \n", -1);
      checkpoint("held_a", 64'hAABBCCDDEEFF0011);
      send_line("12 34 56 78 9a bc de f0 \n", -1);
      checkpoint("ovf_b", 64'hAABBCCDDEEFF0011);
      if (held_v) exp_q.push_back(held_w);
      held_v = 0;
      qword_ready = 1'b1;
      checkpoint("drain_a", 64'hAABBCCDDEEFF0011);

      send_line("F0 0F 11 22 33 44 55 66 \n", 4);
      checkpoint("frame", 64'hAABBCCDDEEFF0011);
      send_line("10 20 30 40 50 60 70 80 \n", -1);
      checkpoint("after_frame", 64'h1020304050607080);

      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(3 * C);
      checkpoint("glitch", 64'h1020304050607080);

      ln = "99 88 77 66 55 44 33 22 \n";
      for (int i = 0; i < 4; i++) send_byte(ln[i], 1'b1);
      rx = 1'b0;
      tick(C + 3);
      rst = 1'b0;
      tick(2);
      check_reset_outputs("mid_rst");
      rx = 1'b1;
      tick(5);
      exp_q.delete();
      held_v = 0;
      rst = 1'b1;
      tick(3 * C);
      checkpoint("post_rst", 64'd0);
      send_line("C0 FF EE 12 34 56 78 9A \n", -1);
      checkpoint("rst_line", 64'hC0FFEE123456789A);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
